fpu_issue_ctrl: RTL and testbench

- Sequences the multi-cycle FPU in the execute stage.
- Accepts one FPU operation at a time and times its latency from a fixed per-opcode table.
- Holds off further FPU issue while busy, and reports RAW hazards against the in-flight destination register to the hazard logic.
- Emits a one-cycle completion strobe with destination and write-enable for the writeback path.

---
 rtl/fpu_issue_ctrl_if.sv | 27 ++
 rtl/fpu_issue_ctrl.sv | 65 ++++++
 tb/tb_fpu_issue_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: issue/hazard/writeback signal bundle between execute stage (master) and FPU issue controller (slave)
interface fpu_issue_ctrl_if #(
  parameter int REGW = 6,
  parameter int OPW  = 5
);
  logic            issue_valid;
  logic [OPW-1:0]  issue_op;
  logic [REGW-1:0] issue_dst;
  logic            issue_wen;
  logic            issue_ready;
  logic            busy;
  logic            flush;
  logic [REGW-1:0] query_rs;
  logic [REGW-1:0] query_rt;
  logic            raw_hit;
  logic            done;
  logic [REGW-1:0] done_dst;
  logic            done_wen;
  modport master (
    output issue_valid, issue_op, issue_dst, issue_wen, flush, query_rs, query_rt,
    input  issue_ready, busy, raw_hit, done, done_dst, done_wen
  );
  modport slave (
    input  issue_valid, issue_op, issue_dst, issue_wen, flush, query_rs, query_rt,
    output issue_ready, busy, raw_hit, done, done_dst, done_wen
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: times one multi-cycle FPU op, blocks issue while busy, flags RAW hazards, strobes completion
// Ports: clk, rstn (async active-low); bus (slave): issue_valid/op/dst/wen in, issue_ready/busy out,
// flush in, query_rs/rt in, raw_hit out, done/done_dst/done_wen out.
module fpu_issue_ctrl #(
  parameter int REGW = 6,
  parameter int OPW  = 5,
  parameter int CNTW = 3
) (
  input logic            clk,
  input logic            rstn,
  fpu_issue_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t          r_state, w_next;
  logic [CNTW-1:0] r_cnt, w_lat;
  logic [REGW-1:0] r_dst;
  logic            r_wen, w_accept;
  always_comb begin
    w_lat = '0;
    case (bus.issue_op)
      OPW'(5'b00001), OPW'(5'b00011): w_lat = CNTW'(3);
      OPW'(5'b00101), OPW'(5'b01101): w_lat = CNTW'(2);
      OPW'(5'b00111):                 w_lat = CNTW'(5);
      OPW'(5'b10001), OPW'(5'b10011),
      OPW'(5'b10101):                 w_lat = CNTW'(1);
      default:                        w_lat = '0;
    endcase
  end
  assign w_accept = bus.issue_valid && bus.issue_op[0] && bus.issue_ready && !bus.flush;
  // accept is impossible in BUSY, so the accept arm only ever fires from IDLE or DONE
  always_comb begin
    w_next = bus.flush ? IDLE
           : w_accept ? ((w_lat == '0) ? DONE : BUSY)
           : (r_state == BUSY) ? ((r_cnt <= CNTW'(1)) ? DONE : BUSY)
           : IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dst   <= '0;
      r_wen   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt <= w_lat;
        r_dst <= bus.issue_dst;
        r_wen <= bus.issue_wen && (bus.issue_dst != '0);
      end else if (bus.flush) begin
        r_cnt <= '0;
        r_wen <= 1'b0;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
  assign bus.issue_ready = (r_state != BUSY);
  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = (r_state == DONE);
  assign bus.done_dst    = bus.done ? r_dst : '0;
  assign bus.done_wen    = bus.done && r_wen;
  // in DONE the result is forwarded by writeback, so only BUSY reports a hazard
  assign bus.raw_hit     = (r_state == BUSY) && r_wen &&
                           ((bus.query_rs == r_dst) || (bus.query_rt == r_dst));
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: table-driven per-cycle vectors plus flush/reset corner sequences for fpu_issue_ctrl
module tb_fpu_issue_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  fpu_issue_ctrl_if #(.REGW(6), .OPW(5)) bus ();
  fpu_issue_ctrl #(.REGW(6), .OPW(5), .CNTW(3)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  typedef struct {
    logic       v;
    logic [4:0] op;
    logic [5:0] dst;
    logic       wen;
    logic       fl;
    logic [5:0] rs;
    logic [5:0] rt;
    logic       rdy;
    logic       bsy;
    logic       raw;
    logic       dn;
    logic [5:0] ddst;
    logic       dwen;
  } vec_t;
  vec_t tv[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic chk_out(input string t, input logic rdy, input logic bsy, input logic raw,
                         input logic dn, input logic [5:0] ddst, input logic dwen);
    chk({t, ".ready"}, 32'(bus.issue_ready), 32'(rdy));
    chk({t, ".busy"}, 32'(bus.busy), 32'(bsy));
    chk({t, ".raw_hit"}, 32'(bus.raw_hit), 32'(raw));
    chk({t, ".done"}, 32'(bus.done), 32'(dn));
    chk({t, ".done_dst"}, 32'(bus.done_dst), 32'(ddst));
    chk({t, ".done_wen"}, 32'(bus.done_wen), 32'(dwen));
  endtask
  task automatic drive(input logic v, input logic [4:0] op, input logic [5:0] dst, input logic wen,
                       input logic fl, input logic [5:0] rs, input logic [5:0] rt);
    bus.issue_valid = v;
    bus.issue_op    = op;
    bus.issue_dst   = dst;
    bus.issue_wen   = wen;
    bus.flush       = fl;
    bus.query_rs    = rs;
    bus.query_rt    = rt;
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic add(input logic v, input logic [4:0] op, input logic [5:0] dst, input logic wen,
                     input logic [5:0] rs, input logic [5:0] rt, input logic rdy, input logic bsy,
                     input logic raw, input logic dn, input logic [5:0] ddst, input logic dwen);
    tv.push_back('{v, op, dst, wen, 1'b0, rs, rt, rdy, bsy, raw, dn, ddst, dwen});
  endtask
  initial begin
    //  v  op        dst wen rs  rt   rdy bsy raw dn ddst dwen
    add(1, 5'b00001, 5,  1,  0,  0,   1,  0,  0,  0, 0,   0);
    add(0, 5'b00000, 0,  0,  5,  0,   0,  1,  1,  0, 0,   0);
    add(0, 5'b00000, 0,  0,  0,  5,   0,  1,  1,  0, 0,   0);
    add(0, 5'b00000, 0,  0,  6,  6,   0,  1,  0,  0, 0,   0);
    add(0, 5'b00000, 0,  0,  5,  5,   1,  1,  0,  1, 5,   1);
    add(1, 5'b00111, 7,  1,  7,  0,   1,  0,  0,  0, 0,   0);
    add(0, 5'b00000, 0,  0,  7,  0,   0,  1,  1,  0, 0,   0);
    add(0, 5'b00000, 0,  0,  0,  7,   0,  1,  1,  0, 0,   0);
    add(0, 5'b00000, 0,  0,  7,  0,   0,  1,  1,  0, 0,   0);
    add(0, 5'b00000, 0,  0,  7,  7,   0,  1,  1,  0, 0,   0);
    add(0, 5'b00000, 0,  0,  8,  8,   0,  1,  0,  0, 0,   0);
    add(1, 5'b01001, 3,  1,  7,  7,   1,  1,  0,  1, 7,   1);
    add(1, 5'b10001, 4,  0,  3,  3,   1,  1,  0,  1, 3,   1);
    add(0, 5'b00000, 0,  0,  4,  4,   0,  1,  0,  0, 0,   0);
    add(1, 5'b00101, 0,  1,  0,  0,   1,  1,  0,  1, 4,   0);
    add(0, 5'b00000, 0,  0,  0,  0,   0,  1,  0,  0, 0,   0);
    add(0, 5'b00000, 0,  0,  0,  0,   0,  1,  0,  0, 0,   0);
    add(1, 5'b00010, 9,  1,  0,  0,   1,  1,  0,  1, 0,   0);
    add(1, 5'b01101, 2,  1,  9,  9,   1,  0,  0,  0, 0,   0);
    add(0, 5'b00000, 0,  0,  2,  0,   0,  1,  1,  0, 0,   0);
    add(0, 5'b00000, 0,  0,  0,  2,   0,  1,  1,  0, 0,   0);
    add(1, 5'b10101, 1,  1,  2,  2,   1,  1,  0,  1, 2,   1);
    add(0, 5'b00000, 0,  0,  1,  3,   0,  1,  1,  0, 0,   0);
    add(1, 5'b11111, 6,  1,  0,  0,   1,  1,  0,  1, 1,   1);
    add(1, 5'b10011, 10, 1,  6,  6,   1,  1,  0,  1, 6,   1);
    add(0, 5'b00000, 0,  0,  10, 0,   0,  1,  1,  0, 0,   0);
    add(0, 5'b00000, 0,  0,  0,  0,   1,  1,  0,  1, 10,  1);
    add(0, 5'b00000, 0,  0,  0,  0,   1,  0,  0,  0, 0,   0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #12;
    chk_out("reset", 1, 0, 0, 0, 0, 0);
    #10 rstn = 1'b1;
    tick();
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].v, tv[i].op, tv[i].dst, tv[i].wen, tv[i].fl, tv[i].rs, tv[i].rt);
      #1;
      chk_out($sformatf("vec%0d", i), tv[i].rdy, tv[i].bsy, tv[i].raw, tv[i].dn, tv[i].ddst, tv[i].dwen);
      tick();
    end
    // flush during BUSY with a competing issue: flush wins, op is dropped silently
    drive(1, 5'b00111, 7, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 7, 0);
    tick();
    tick();
    drive(1, 5'b00001, 9, 1, 1, 7, 0);
    #1;
    chk_out("flush_busy", 0, 1, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 7, 9);
    #1;
    chk_out("after_flush", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("no_done_flush%0d", i), 32'(bus.done), 32'd0);
      chk($sformatf("idle_flush%0d", i), 32'(bus.busy), 32'd0);
    end
    drive(1, 5'b00001, 5, 1, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_out("flush_idle", 1, 0, 0, 0, 0, 0);
    // flush in DONE lets the current completion strobe finish
    drive(1, 5'b01001, 12, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 12, 0);
    #1;
    chk_out("flush_done", 1, 1, 0, 1, 12, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_out("after_flush_done", 1, 0, 0, 0, 0, 0);
    // asynchronous reset mid-operation
    drive(1, 5'b00011, 5, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 5, 0);
    #1;
    chk_out("pre_reset", 0, 1, 1, 0, 0, 0);
    #2 rstn = 1'b0;
    #1;
    chk_out("async_reset", 1, 0, 0, 0, 0, 0);
    #2 rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("no_done_rst%0d", i), 32'(bus.done), 32'd0);
      chk($sformatf("idle_rst%0d", i), 32'(bus.busy), 32'd0);
    end
    drive(1, 5'b00010, 5, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("even_op%0d", i), 32'(bus.busy), 32'd0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
